// File: rtl/mage_cfg_loader.sv
// mage_cfg_loader
//   Streams a configuration image into the peripheral register file.
//   Each 32-bit word taken from the cfg stream becomes one register-bus
//   write to base + 4*idx; with VERIFY set every write is followed by a
//   read of the same address and compared against the word just written.
//   A per-transaction timeout catches a responder that never answers.
//
// Ports
//   clk_i, rst_n_i         clock, asynchronous active-low reset
//   start_i                start a run (only looked at in IDLE)
//   base_addr_i            word-aligned byte address of the first register
//   num_words_i            number of words to load (0 = empty run)
//   abort_i                request early termination
//   cfg_data_i/valid_i     configuration word stream in
//   cfg_ready_o            loader accepts a word (FETCH only)
//   reg_req_o / reg_rsp_i  register-bus request out / response in
//   busy_o                 high whenever not IDLE
//   done_o                 one-cycle pulse at the end of every run
//   error_o                sticky error flag, cleared by the next start
//   error_code_o           0 none, 1 bus error, 2 mismatch, 3 timeout
//   error_idx_o            word index at which the error was recorded
`timescale 1ns/1ps

package mage_cfg_loader_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;
endpackage

module mage_cfg_loader
    import mage_cfg_loader_pkg::*;
#(
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter bit          VERIFY         = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic [31:0]      base_addr_i,
    input  logic [CNT_W-1:0] num_words_i,
    input  logic             abort_i,
    input  logic [31:0]      cfg_data_i,
    input  logic             cfg_valid_i,
    output logic             cfg_ready_o,
    output reg_req_t         reg_req_o,
    input  reg_rsp_t         reg_rsp_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o,
    output logic [1:0]       error_code_o,
    output logic [CNT_W-1:0] error_idx_o
);

    localparam int unsigned     TO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] CODE_BUS      = 2'd1;
    localparam logic [1:0] CODE_MISMATCH = 2'd2;
    localparam logic [1:0] CODE_TIMEOUT  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WRITE,
        ST_READ,
        ST_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      base_q, base_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [31:0]      data_q, data_d;
    logic             abort_q, abort_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;
    logic [CNT_W-1:0] eidx_q, eidx_d;
    logic [TO_W-1:0]  tcnt_q, tcnt_d;
    reg_req_t         req_q, req_d;

    logic             advance;
    logic             rec_err;
    logic [1:0]       rec_code;

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        data_d   = data_q;
        abort_d  = abort_q;
        err_d    = err_q;
        code_d   = code_q;
        eidx_d   = eidx_q;
        tcnt_d   = '0;          // any entry into WRITE/READ starts from zero
        advance  = 1'b0;
        rec_err  = 1'b0;
        rec_code = '0;

        if (state_q != ST_IDLE && abort_i) begin
            abort_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    base_d  = base_addr_i;
                    cnt_d   = num_words_i;
                    idx_d   = '0;
                    err_d   = 1'b0;
                    code_d  = '0;
                    eidx_d  = '0;
                    abort_d = 1'b0;
                    state_d = (num_words_i == '0) ? ST_DONE : ST_FETCH;
                end
            end
            ST_FETCH: begin
                // Abort wins over a word offered in the same cycle; the run
                // is being torn down so that word is simply not written.
                if (abort_d) begin
                    state_d = ST_DONE;
                end else if (cfg_valid_i) begin
                    data_d  = cfg_data_i;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (reg_rsp_i.ready) begin
                    if (reg_rsp_i.error) begin
                        rec_err  = 1'b1;
                        rec_code = CODE_BUS;
                        state_d  = ST_DONE;
                    end else if (abort_d) begin
                        // A pending abort skips the read-back of this word.
                        state_d = ST_DONE;
                    end else if (VERIFY) begin
                        state_d = ST_READ;
                    end else begin
                        advance = 1'b1;
                    end
                end else if (tcnt_q == TO_LAST) begin
                    rec_err  = 1'b1;
                    rec_code = CODE_TIMEOUT;
                    state_d  = ST_DONE;
                end else begin
                    tcnt_d = tcnt_q + TO_W'(1);
                end
            end
            ST_READ: begin
                if (reg_rsp_i.ready) begin
                    if (reg_rsp_i.error) begin
                        rec_err  = 1'b1;
                        rec_code = CODE_BUS;
                        state_d  = ST_DONE;
                    end else if (reg_rsp_i.rdata != data_q) begin
                        rec_err  = 1'b1;
                        rec_code = CODE_MISMATCH;
                        state_d  = ST_DONE;
                    end else begin
                        advance = 1'b1;
                    end
                end else if (tcnt_q == TO_LAST) begin
                    rec_err  = 1'b1;
                    rec_code = CODE_TIMEOUT;
                    state_d  = ST_DONE;
                end else begin
                    tcnt_d = tcnt_q + TO_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (advance) begin
            if (abort_d || idx_q == cnt_q - CNT_W'(1)) begin
                state_d = ST_DONE;
            end else begin
                idx_d   = idx_q + CNT_W'(1);
                state_d = ST_FETCH;
            end
        end

        // First error of a run is the one reported.
        if (rec_err && !err_q) begin
            err_d  = 1'b1;
            code_d = rec_code;
            eidx_d = idx_q;
        end

        // Request is a registered image of the next state so that the
        // fields stay constant for the whole life of a transaction.
        req_d = '0;
        if (state_d == ST_WRITE) begin
            req_d.valid = 1'b1;
            req_d.write = 1'b1;
            req_d.addr  = base_d + (32'(idx_d) << 2);
            req_d.wdata = data_d;
            req_d.wstrb = 4'hF;
        end else if (state_d == ST_READ) begin
            req_d.valid = 1'b1;
            req_d.addr  = base_d + (32'(idx_d) << 2);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            abort_q <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= '0;
            eidx_q  <= '0;
            tcnt_q  <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            abort_q <= abort_d;
            err_q   <= err_d;
            code_q  <= code_d;
            eidx_q  <= eidx_d;
            tcnt_q  <= tcnt_d;
            req_q   <= req_d;
        end
    end

    assign reg_req_o    = req_q;
    assign cfg_ready_o  = (state_q == ST_FETCH);
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = (state_q == ST_DONE);
    assign error_o      = err_q;
    assign error_code_o = code_q;
    assign error_idx_o  = eidx_q;

endmodule

// File: tb/tb_mage_cfg_loader.sv
`timescale 1ns/1ps

module tb_mage_cfg_loader;
    import mage_cfg_loader_pkg::*;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } txn_t;

    typedef struct {
        int          dut;
        logic [31:0] base;
        int          cnt;
        int          stall;
        int          berr;
        int          bad;
        int          code;
        int          eidx;
        int          nreq;
        int          done_at;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        start_s[2];
    logic [31:0] base_s[2];
    logic [15:0] num_s[2];
    logic        abort_s[2];
    logic [31:0] cdata[2];
    logic        cvalid[2];
    logic        cready[2];
    reg_req_t    req[2];
    reg_rsp_t    rsp[2];
    logic        busy[2];
    logic        done[2];
    logic        err[2];
    logic [1:0]  code[2];
    logic [15:0] eidx[2];

    // dut 0: writes only, dut 1: read-back verify; both time out after 8 waits
    mage_cfg_loader #(.CNT_W(16), .TIMEOUT_CYCLES(8), .VERIFY(0)) u_v0 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start_s[0]), .base_addr_i(base_s[0]),
        .num_words_i(num_s[0]), .abort_i(abort_s[0]), .cfg_data_i(cdata[0]),
        .cfg_valid_i(cvalid[0]), .cfg_ready_o(cready[0]), .reg_req_o(req[0]),
        .reg_rsp_i(rsp[0]), .busy_o(busy[0]), .done_o(done[0]), .error_o(err[0]),
        .error_code_o(code[0]), .error_idx_o(eidx[0]));

    mage_cfg_loader #(.CNT_W(16), .TIMEOUT_CYCLES(8), .VERIFY(1)) u_v1 (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start_s[1]), .base_addr_i(base_s[1]),
        .num_words_i(num_s[1]), .abort_i(abort_s[1]), .cfg_data_i(cdata[1]),
        .cfg_valid_i(cvalid[1]), .cfg_ready_o(cready[1]), .reg_req_o(req[1]),
        .reg_rsp_i(rsp[1]), .busy_o(busy[1]), .done_o(done[1]), .error_o(err[1]),
        .error_code_o(code[1]), .error_idx_o(eidx[1]));

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int t0 = 0;
    int a = 0;

    // responder / source knobs
    int          stall_cfg = 0;
    bit          hang = 0;
    bit          gaps = 0;
    int          berr_idx = -1;
    int          bad_idx = -1;
    logic [31:0] cur_base = '0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] words_q[$];
    logic [31:0] src_q[$];
    txn_t        log_q[$];
    txn_t        exp_q[$];
    int          exp_code, exp_eidx;

    int fetched, done_cnt, done_rel, ready_cnt, vld_cnt;
    bit busy_at_done, busy_after, done_prev;

    int       wcnt[2];
    bit       stall_prev[2];
    reg_req_t prev_req[2];

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s act=0x%0h exp=0x%0h", nm, act, exp);
        end
    endtask

    // Register-bus responder: memory model with programmable wait states,
    // bus error on one write index and corrupted read-back on one index.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (req[d].valid) begin
                reg_rsp_t r;
                int       ix;
                bit       rdy;
                txn_t     t;
                if (stall_prev[d]) chk("stable", req[d], prev_req[d]);
                ix  = int'((req[d].addr - cur_base) >> 2);
                rdy = !hang && wcnt[d] >= stall_cfg;
                r   = '0;
                r.ready = rdy;
                if (rdy) begin
                    r.error = req[d].write && ix == berr_idx;
                    if (!req[d].write) begin
                        r.rdata = mem.exists(req[d].addr) ? mem[req[d].addr] : 32'h0;
                        if (ix == bad_idx) r.rdata = r.rdata ^ 32'h1;
                    end
                    t.write = req[d].write;
                    t.addr  = req[d].addr;
                    t.data  = req[d].wdata;
                    t.strb  = req[d].wstrb;
                    log_q.push_back(t);
                    if (req[d].write && !r.error) mem[req[d].addr] = req[d].wdata;
                    wcnt[d] = 0;
                end else begin
                    wcnt[d]++;
                end
                stall_prev[d] = !rdy;
                prev_req[d]   = req[d];
                rsp[d]        = r;
            end else begin
                rsp[d]        = '0;
                wcnt[d]       = 0;
                stall_prev[d] = 1'b0;
            end
        end
    end

    // Word source with optional random gaps
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) if (d != a) cvalid[d] = 1'b0;
        if (src_q.size() > 0 && !(gaps && $urandom_range(0, 2) == 0)) begin
            cvalid[a] = 1'b1;
            cdata[a]  = src_q[0];
            if (cready[a]) begin
                void'(src_q.pop_front());
                fetched++;
            end
        end else begin
            cvalid[a] = 1'b0;
            cdata[a]  = '0;
        end
    end

    // Run observer
    always @(negedge clk) begin
        if (done[a]) begin
            done_cnt++;
            done_rel     = cyc - t0;
            busy_at_done = busy[a];
        end
        if (done_prev) busy_after = busy[a];
        done_prev = done[a];
        if (cready[a]) ready_cnt++;
        if (req[a].valid) vld_cnt++;
    end

    // Expected bus traffic and error outcome of a run, straight from the rules:
    // word i -> write base+4i; with verify a read of the same address follows.
    task automatic build_exp(input int verify, input logic [31:0] b, input int n,
                             input int be, input int bd);
        txn_t        t;
        logic [31:0] ad;
        exp_q.delete();
        exp_code = 0;
        exp_eidx = 0;
        for (int i = 0; i < n; i++) begin
            ad = b + 32'(i) * 32'd4;
            t.write = 1'b1; t.addr = ad; t.data = words_q[i]; t.strb = 4'hF;
            exp_q.push_back(t);
            if (i == be) begin exp_code = 1; exp_eidx = i; break; end
            if (verify != 0) begin
                t.write = 1'b0; t.addr = ad; t.data = 32'h0; t.strb = 4'h0;
                exp_q.push_back(t);
                if (i == bd) begin exp_code = 2; exp_eidx = i; break; end
            end
        end
    endtask

    task automatic start_run(input int d, input logic [31:0] b, input int n);
        a = d;
        cur_base = b;
        log_q.delete();
        fetched = 0; done_cnt = 0; done_rel = -1; ready_cnt = 0; vld_cnt = 0;
        busy_at_done = 0; busy_after = 1; done_prev = 0;
        src_q = words_q;
        @(negedge clk);
        start_s[d] = 1'b1;
        base_s[d]  = b;
        num_s[d]   = 16'(n);
        t0 = cyc;
        @(negedge clk);
        start_s[d] = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk({nm, "_done_once"}, done_cnt, 1);
        chk({nm, "_busy_at_done"}, busy_at_done, 1);
        chk({nm, "_busy_after"}, busy_after, 0);
    endtask

    task automatic check_run(input string nm);
        int m;
        chk({nm, "_nreq"}, log_q.size(), exp_q.size());
        m = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
        for (int i = 0; i < m; i++) begin
            chk($sformatf("%s_wr%0d", nm, i), log_q[i].write, exp_q[i].write);
            chk($sformatf("%s_addr%0d", nm, i), log_q[i].addr, exp_q[i].addr);
            chk($sformatf("%s_data%0d", nm, i), log_q[i].data, exp_q[i].data);
            if (exp_q[i].write) chk($sformatf("%s_strb%0d", nm, i), log_q[i].strb, 4'hF);
        end
        chk({nm, "_code"}, code[a], exp_code);
        chk({nm, "_eidx"}, eidx[a], exp_eidx);
        chk({nm, "_err"}, err[a], exp_code != 0);
    endtask

    vec_t        vecs[7];
    logic [31:0] rb;
    int          rn, rd;

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            start_s[d] = 0; base_s[d] = '0; num_s[d] = '0; abort_s[d] = 0;
        end

        //           dut base          cnt st berr bad code eidx nreq done
        vecs[0] = '{0, 32'h0000_0100, 3, 0, -1, -1, 0, 0, 3, 7};
        vecs[1] = '{1, 32'h0000_0200, 2, 0, -1, -1, 0, 0, 4, 7};
        vecs[2] = '{1, 32'h0000_0200, 2, 0, -1,  1, 2, 1, 4, 7};
        vecs[3] = '{0, 32'h0000_0300, 0, 0, -1, -1, 0, 0, 0, 1};
        vecs[4] = '{1, 32'h0000_0400, 3, 0,  1, -1, 1, 1, 3, 6};
        vecs[5] = '{0, 32'hFFFF_FFF8, 3, 0, -1, -1, 0, 0, 3, 7};
        vecs[6] = '{0, 32'h0000_0500, 2, 3, -1, -1, 0, 0, 2, 11};

        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("rst_req%0d", d), req[d], 0);
            chk($sformatf("rst_ready%0d", d), cready[d], 0);
            chk($sformatf("rst_busy%0d", d), busy[d], 0);
            chk($sformatf("rst_done%0d", d), done[d], 0);
            chk($sformatf("rst_err%0d", d), err[d], 0);
            chk($sformatf("rst_code%0d", d), code[d], 0);
            chk($sformatf("rst_eidx%0d", d), eidx[d], 0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // table-driven runs with an always-valid source
        for (int v = 0; v < 7; v++) begin
            string nm;
            nm = $sformatf("vec%0d", v);
            words_q.delete();
            for (int i = 0; i < vecs[v].cnt; i++) words_q.push_back(32'hA + 32'(i) + (32'(v) << 8));
            stall_cfg = vecs[v].stall; berr_idx = vecs[v].berr; bad_idx = vecs[v].bad;
            gaps = 0; hang = 0;
            start_run(vecs[v].dut, vecs[v].base, vecs[v].cnt);
            wait_done(nm, 200);
            build_exp(vecs[v].dut, vecs[v].base, vecs[v].cnt, vecs[v].berr, vecs[v].bad);
            check_run(nm);
            chk({nm, "_tcode"}, code[a], vecs[v].code);
            chk({nm, "_teidx"}, eidx[a], vecs[v].eidx);
            chk({nm, "_tnreq"}, log_q.size(), vecs[v].nreq);
            chk({nm, "_done_at"}, done_rel, vecs[v].done_at);
            if (vecs[v].cnt == 0) chk({nm, "_no_ready"}, ready_cnt, 0);
        end

        // responder never answers: 8 wait cycles then timeout
        words_q = '{32'h1111_0000, 32'h2222_0000};
        stall_cfg = 0; berr_idx = -1; bad_idx = -1; hang = 1;
        start_run(0, 32'h0000_0800, 2);
        wait_done("tmo", 100);
        chk("tmo_valid_cycles", vld_cnt, 8);
        chk("tmo_done_at", done_rel, 10);
        chk("tmo_code", code[0], 3);
        chk("tmo_eidx", eidx[0], 0);
        chk("tmo_err", err[0], 1);
        chk("tmo_nreq", log_q.size(), 0);
        hang = 0;

        // abort during a stalled write of word 1
        words_q = '{32'hAB00_0000, 32'hAB00_0001, 32'hAB00_0002};
        stall_cfg = 3;
        start_run(0, 32'h0000_0900, 3);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (req[0].valid && req[0].addr == 32'h0000_0904) break;
        end
        chk("abt_reached_w1", req[0].addr, 32'h0000_0904);
        abort_s[0] = 1'b1;
        @(negedge clk);
        abort_s[0] = 1'b0;
        wait_done("abt", 100);
        build_exp(0, 32'h0000_0900, 2, -1, -1);
        check_run("abt");
        chk("abt_fetched", fetched, 2);
        chk("abt_done_at", done_rel, 11);

        // second start while busy is ignored
        words_q = '{32'h5A5A_0000, 32'h5A5A_0001};
        stall_cfg = 0;
        start_run(0, 32'h0000_0A00, 2);
        @(negedge clk);
        @(negedge clk);
        start_s[0] = 1'b1; num_s[0] = 16'd5; base_s[0] = 32'h0000_0F00;
        @(negedge clk);
        start_s[0] = 1'b0;
        wait_done("sbusy", 100);
        build_exp(0, 32'h0000_0A00, 2, -1, -1);
        check_run("sbusy");
        chk("sbusy_done_at", done_rel, 5);

        // asynchronous reset in the middle of a write
        words_q = '{32'hC0DE_0000, 32'hC0DE_0001};
        hang = 1;
        start_run(1, 32'h0000_0B00, 2);
        for (int i = 0; i < 20 && !req[1].valid; i++) @(negedge clk);
        chk("mrst_in_write", req[1].valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_req", req[1], 0);
        chk("mrst_ready", cready[1], 0);
        chk("mrst_busy", busy[1], 0);
        chk("mrst_done", done[1], 0);
        chk("mrst_err", err[1], 0);
        chk("mrst_code", code[1], 0);
        chk("mrst_eidx", eidx[1], 0);
        hang = 0;
        src_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // randomized runs against the reference model
        for (int r = 0; r < 30; r++) begin
            rd = $urandom_range(0, 1);
            rb = $urandom;
            rb = rb & 32'hFFFF_FFFC;
            rn = $urandom_range(1, 6);
            words_q.delete();
            for (int i = 0; i < rn; i++) words_q.push_back($urandom);
            stall_cfg = $urandom_range(0, 2);
            gaps      = 1;
            berr_idx  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, rn - 1) : -1;
            bad_idx   = (rd == 1 && $urandom_range(0, 3) == 0) ? $urandom_range(0, rn - 1) : -1;
            start_run(rd, rb, rn);
            wait_done($sformatf("rnd%0d", r), 500);
            build_exp(rd, rb, rn, berr_idx, bad_idx);
            check_run($sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
